// File: rtl/prco_regs.sv
// prco_regs -- general-purpose register file of the PRCO 16-bit core.
//
// Eight 16-bit registers (r0..r7, all writable), two registered read ports
// (A and B) and one write port (D). Everything updates on the rising edge of
// i_clk when the global enable i_en is high. The active-low i_reset clears
// the array and both read outputs asynchronously.
//
// Ports:
//   i_clk    in   1   core clock
//   i_reset  in   1   asynchronous active-low reset
//   i_en     in   1   global enable; 0 freezes the array and both outputs
//   i_sela   in   3   read-port A select
//   q_data   out 16   read-port A data (registered, one-cycle latency)
//   i_selb   in   3   read-port B select
//   q_datb   out 16   read-port B data (registered, one-cycle latency)
//   i_we     in   1   write enable for port D (ignored while i_en=0)
//   i_seld   in   3   write-port D select
//   i_datd   in  16   write-port D data
//
// Port timing: the write and both reads use the same edge. When a read
// select matches the write select on a write edge, the read port returns
// the incoming write data (bypass), so the new value is visible right after
// that edge.

module prco_regs (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic [2:0]  i_sela,
  output logic [15:0] q_data,
  input  logic [2:0]  i_selb,
  output logic [15:0] q_datb,
  input  logic        i_we,
  input  logic [2:0]  i_seld,
  input  logic [15:0] i_datd
);

  logic [7:0][15:0] regs_q, regs_d;
  logic [15:0]      data_q, data_d;
  logic [15:0]      datb_q, datb_d;
  logic             wr_en;
  logic             byp_a;
  logic             byp_b;

  // A write only happens on an enabled edge; i_we alone is not enough.
  assign wr_en = i_en & i_we;
  assign byp_a = wr_en & (i_sela == i_seld);
  assign byp_b = wr_en & (i_selb == i_seld);

  always_comb begin
    regs_d = regs_q;
    data_d = data_q;
    datb_d = datb_q;
    if (wr_en) begin
      regs_d[i_seld] = i_datd;
    end
    if (i_en) begin
      // Read the old array contents unless the same-edge write targets the
      // selected register; then forward the write data.
      data_d = byp_a ? i_datd : regs_q[i_sela];
      datb_d = byp_b ? i_datd : regs_q[i_selb];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      regs_q <= '0;
      data_q <= '0;
      datb_q <= '0;
    end else begin
      regs_q <= regs_d;
      data_q <= data_d;
      datb_q <= datb_d;
    end
  end

  assign q_data = data_q;
  assign q_datb = datb_q;

endmodule

// File: tb/tb_prco_regs.sv
// tb_prco_regs -- directed self-checking bench for prco_regs.
// Inputs change #1 after the rising edge; outputs are sampled at the same
// point, well away from the active edge.

module tb_prco_regs;

  logic        i_clk;
  logic        i_reset;
  logic        i_en;
  logic [2:0]  i_sela;
  logic [15:0] q_data;
  logic [2:0]  i_selb;
  logic [15:0] q_datb;
  logic        i_we;
  logic [2:0]  i_seld;
  logic [15:0] i_datd;

  int n_tests;
  int n_fail;

  logic [15:0] exp_q[$];

  prco_regs dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (i_en),
    .i_sela  (i_sela),
    .q_data  (q_data),
    .i_selb  (i_selb),
    .q_datb  (q_datb),
    .i_we    (i_we),
    .i_seld  (i_seld),
    .i_datd  (i_datd)
  );

  // ---------------------------------------------------------------- clock
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // ---------------------------------------------------------------- check
  task automatic check_eq(input string tag, input logic [15:0] obs,
                          input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // --------------------------------------------------------------- driver
  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic we, input logic [2:0] seld,
                       input logic [15:0] datd, input logic [2:0] sela,
                       input logic [2:0] selb);
    i_en   = en;
    i_we   = we;
    i_seld = seld;
    i_datd = datd;
    i_sela = sela;
    i_selb = selb;
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin
    n_tests = 0;
    n_fail  = 0;
    i_reset = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0);

    // Reset state.
    repeat (3) step();
    check_eq("rst_data", q_data, 16'h0000);
    check_eq("rst_datb", q_datb, 16'h0000);
    i_reset = 1'b1;

    // All registers read zero after reset, on both ports.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, 3'd0, 16'h0000, k[2:0], 3'(7 - k));
      step();
      check_eq("post_rst_a", q_data, 16'h0000);
      check_eq("post_rst_b", q_datb, 16'h0000);
    end

    // Basic write then read.
    drive(1'b1, 1'b1, 3'd1, 16'hF0F0, 3'd0, 3'd0);
    step();
    drive(1'b1, 1'b0, 3'd1, 16'hF0F0, 3'd1, 3'd0);
    step();
    check_eq("wr_rd_r1", q_data, 16'hF0F0);
    check_eq("rd_r0", q_datb, 16'h0000);

    // Enable gating: writes blocked and outputs hold while i_en=0.
    drive(1'b0, 1'b1, 3'd2, 16'h1234, 3'd3, 3'd2);
    repeat (3) step();
    check_eq("en0_hold_a", q_data, 16'hF0F0);
    check_eq("en0_hold_b", q_datb, 16'h0000);
    drive(1'b1, 1'b0, 3'd2, 16'h1234, 3'd2, 3'd1);
    step();
    check_eq("en0_no_wr_r2", q_data, 16'h0000);
    check_eq("en1_rd_r1", q_datb, 16'hF0F0);

    // Bypass on both ports at once.
    drive(1'b1, 1'b1, 3'd3, 16'hABCD, 3'd3, 3'd3);
    step();
    check_eq("byp_a", q_data, 16'hABCD);
    check_eq("byp_b", q_datb, 16'hABCD);
    // Bypass on port A only; port B reads stored r3.
    drive(1'b1, 1'b1, 3'd4, 16'h5A5A, 3'd4, 3'd3);
    step();
    check_eq("byp_a_only", q_data, 16'h5A5A);
    check_eq("no_byp_b", q_datb, 16'hABCD);
    // Bypass on port B only; port A reads stored r4.
    drive(1'b1, 1'b1, 3'd6, 16'h0F0F, 3'd4, 3'd6);
    step();
    check_eq("no_byp_a", q_data, 16'h5A5A);
    check_eq("byp_b_only", q_datb, 16'h0F0F);

    // Full sweep: r_k = 16'h1111 * k, then every (a,b) pair.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b1, k[2:0], 16'(k * 'h1111), 3'd0, 3'd0);
      step();
    end
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        drive(1'b1, 1'b0, 3'd0, 16'hDEAD, a[2:0], b[2:0]);
        exp_q.push_back(16'(a * 'h1111));
        exp_q.push_back(16'(b * 'h1111));
        step();
        check_eq("sweep_a", q_data, exp_q.pop_front());
        check_eq("sweep_b", q_datb, exp_q.pop_front());
      end
    end

    // Reset asserted mid-cycle during a pending write to r5.
    drive(1'b1, 1'b1, 3'd5, 16'hFFFF, 3'd7, 3'd6);
    #2;
    i_reset = 1'b0;
    #1;
    check_eq("async_rst_a", q_data, 16'h0000);
    check_eq("async_rst_b", q_datb, 16'h0000);
    step();
    i_reset = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd7);
    #1;
    check_eq("rel_rst_a", q_data, 16'h0000);
    check_eq("rel_rst_b", q_datb, 16'h0000);
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd7);
    step();
    check_eq("rst_wr_r5", q_data, 16'h0000);
    check_eq("rst_clr_r7", q_datb, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
